// File: rtl/row_element.sv
// One row of a small NPU array: three signed MAC lanes sharing one partial-sum input.
// Each lane captures operands on start, multiplies, then accumulates; row done is the AND of lane dones.

module row_mac #(
    parameter int DW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic signed [DW-1:0]   x,
    input  logic signed [DW-1:0]   w,
    input  logic signed [2*DW-1:0] acc_in,
    output logic signed [2*DW-1:0] acc_out,
    output logic                   done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]             r_state;
    logic signed [DW-1:0]   r_x;
    logic signed [DW-1:0]   r_w;
    logic signed [2*DW-1:0] r_acc;
    logic signed [2*DW-1:0] product;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_w     <= '0;
            r_acc   <= '0;
            product <= '0;
            acc_out <= '0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // acc_out and product keep their old values until the new operation reaches them
                    if (start) begin
                        r_x     <= x;
                        r_w     <= w;
                        r_acc   <= acc_in;
                        done    <= 1'b0;
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    product <= (2*DW)'(r_x) * (2*DW)'(r_w);
                    r_state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    acc_out <= r_acc + product;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

module row_element #(
    parameter int DW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic signed [DW-1:0]   x0,
    input  logic signed [DW-1:0]   x1,
    input  logic signed [DW-1:0]   x2,
    input  logic signed [DW-1:0]   w0,
    input  logic signed [DW-1:0]   w1,
    input  logic signed [DW-1:0]   w2,
    input  logic signed [2*DW-1:0] acc_in,
    output logic signed [2*DW-1:0] acc0_out,
    output logic signed [2*DW-1:0] acc1_out,
    output logic signed [2*DW-1:0] acc2_out,
    output logic                   done
);

    logic [2:0] w_lane_done;

    row_mac #(.DW(DW)) mac0 (
        .clk(clk), .rst(rst), .start(start), .x(x0), .w(w0),
        .acc_in(acc_in), .acc_out(acc0_out), .done(w_lane_done[0])
    );

    row_mac #(.DW(DW)) mac1 (
        .clk(clk), .rst(rst), .start(start), .x(x1), .w(w1),
        .acc_in(acc_in), .acc_out(acc1_out), .done(w_lane_done[1])
    );

    row_mac #(.DW(DW)) mac2 (
        .clk(clk), .rst(rst), .start(start), .x(x2), .w(w2),
        .acc_in(acc_in), .acc_out(acc2_out), .done(w_lane_done[2])
    );

    assign done = &w_lane_done;

endmodule

// File: tb/tb_row_element.sv
// Directed bench for row_element: hand-computed vectors covering reset, MAC results,
// busy-start rejection, restart, wraparound and asynchronous reset mid-operation.

module tb_row_element;

    localparam int DW = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic signed [DW-1:0]   x0, x1, x2, w0, w1, w2;
    logic signed [2*DW-1:0] acc_in;
    logic signed [2*DW-1:0] acc0_out, acc1_out, acc2_out;
    logic                   done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    row_element #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .x1(x1), .x2(x2),
        .w0(w0), .w1(w1), .w2(w2),
        .acc_in(acc_in),
        .acc0_out(acc0_out), .acc1_out(acc1_out), .acc2_out(acc2_out),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)",
                     tag, got, $signed(got), exp, $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int a, input int xa, input int xb, input int xc,
                           input int wa, input int wb, input int wc);
        acc_in = 32'(a);
        x0 = 16'(xa); x1 = 16'(xb); x2 = 16'(xc);
        w0 = 16'(wa); w1 = 16'(wb); w2 = 16'(wc);
    endtask

    task automatic check_accs(input string tag, input int e0, input int e1, input int e2);
        check({tag, ".acc0"}, acc0_out, 32'(e0));
        check({tag, ".acc1"}, acc1_out, 32'(e1));
        check({tag, ".acc2"}, acc2_out, 32'(e2));
    endtask

    task automatic check_prods(input string tag, input int p0, input int p1, input int p2);
        check({tag, ".prod0"}, dut.mac0.product, 32'(p0));
        check({tag, ".prod1"}, dut.mac1.product, 32'(p1));
        check({tag, ".prod2"}, dut.mac2.product, 32'(p2));
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0);

        // 1: reset
        tick(); tick();
        rst = 1'b1;
        tick();
        check_accs("rst", 0, 0, 0);
        check_prods("rst", 0, 0, 0);
        check("rst.done", {31'b0, done}, 32'd0);

        // 2: basic MAC, one-cycle start
        set_ops(0, 3, -2, 7, 4, 5, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2.done_cap", {31'b0, done}, 32'd0);
        tick();
        check_prods("t2", 12, -10, -7);
        check("t2.done_prod", {31'b0, done}, 32'd0);
        check_accs("t2.held", 0, 0, 0);
        tick();
        check_accs("t2", 12, -10, -7);
        check("t2.done", {31'b0, done}, 32'd1);
        check("t2.sum", acc0_out + acc1_out + acc2_out, -32'sd5);

        // 3: restart from DONE with nonzero partial sum; old result held until compute edge
        set_ops(100, 2, 2, 2, 10, -3, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3.done_drop", {31'b0, done}, 32'd0);
        check_accs("t3.old", 12, -10, -7);
        tick();
        check_prods("t3", 20, -6, 8);
        check_accs("t3.old2", 12, -10, -7);
        tick();
        check_accs("t3", 120, 94, 108);
        check("t3.done", {31'b0, done}, 32'd1);
        check("t3.sum", acc0_out + acc1_out + acc2_out, 32'd322);

        // 4: operands change after capture, second start during CAPTURE ignored
        set_ops(5, 1, 2, 3, 4, 5, 6);
        start = 1'b1;
        tick();
        set_ops(999, 100, 200, 300, 7, 8, 9);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_prods("t4", 4, 10, 18);
        tick();
        check_accs("t4", 9, 15, 23);
        check("t4.done", {31'b0, done}, 32'd1);
        tick(); tick();
        check_accs("t4.hold", 9, 15, 23);
        check("t4.done_hold", {31'b0, done}, 32'd1);

        // 5: extreme product and wraparound
        set_ops(32'h7FFFFFFF, -32768, 0, -1, -32768, 0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_prods("t5", 32'h40000000, 0, -1);
        tick();
        check_accs("t5", 32'hBFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFE);
        check("t5.done", {31'b0, done}, 32'd1);

        // 6: asynchronous reset while in COMPUTE
        set_ops(1, 1, 1, 1, 1, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("t6.done_rst", {31'b0, done}, 32'd0);
        check_accs("t6.rst", 0, 0, 0);
        check_prods("t6.rst", 0, 0, 0);
        tick();
        check_accs("t6.rst_hold", 0, 0, 0);
        rst = 1'b1;
        set_ops(-7, -5, 6, 100, 3, -4, 100);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_accs("t6.fresh", -22, -31, 9993);
        check("t6.done", {31'b0, done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got stuck expected completion");
        $fatal(1, "timeout");
    end

endmodule
